// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM encoding and default geometry for the program counter sequencer.
package pc_pkg;
    localparam int PC_MSB      = 11;
    localparam int PC_RESET_PC = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } pc_state_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry, and a pop when empty is refused. Both cases pulse err_o.
module pc_ras #(
    parameter int MSB       = 11,
    parameter int RAS_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [MSB-1:0] data_i,
    output logic [MSB-1:0] top_o,
    output logic           empty_o,
    output logic           err_o
);
    localparam int AW = $clog2(RAS_DEPTH);

    logic [MSB-1:0] mem_q [RAS_DEPTH];
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           full;

    assign full    = cnt_q == (AW+1)'(RAS_DEPTH);
    assign empty_o = cnt_q == '0;
    assign top_o   = mem_q[ptr_q];
    assign err_o   = err_q;

    // pointer/count next state; push takes priority over pop
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (push_i) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
            err_d = full;
        end else if (pop_i) begin
            ptr_d = empty_o ? ptr_q : ptr_q - 1'b1;
            cnt_d = empty_o ? cnt_q : cnt_q - 1'b1;
            err_d = empty_o;
        end
    end

    // stack pointer and error pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // entry storage; contents are meaningless while the count says empty
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[ptr_d] <= data_i;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: run-controlled program counter with jump/branch/step updates and wrap flag; define PC_RAS_EN to add call/return via a return-address stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int MSB       = PC_MSB,
    parameter int RESET_PC  = PC_RESET_PC,
    parameter int RAS_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           enable,
    input  logic           i_stall,
    input  logic           i_halt,
    input  logic [MSB-1:0] i_inc,
    input  logic           i_branch,
    input  logic [MSB-1:0] i_offset,
    input  logic           i_jump,
    input  logic [MSB-1:0] i_target,
`ifdef PC_RAS_EN
    input  logic           i_call,
    input  logic           i_ret,
    output logic           o_ras_err,
`endif
    output logic [MSB-1:0] o_pc,
    output logic           o_valid,
    output logic           o_halted,
    output logic           o_wrap
);
    localparam logic [MSB-1:0] RST_PC = MSB'(RESET_PC);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two and at least 2");
    end

    pc_state_e      state_q, state_d;
    logic [MSB-1:0] pc_q, pc_d;
    logic           wrap_q, wrap_d;
    logic [MSB:0]   inc_sum, br_sum;

    // one extra bit catches the carry on a step and the out-of-range sign on a branch
    assign inc_sum = {1'b0, pc_q} + {1'b0, i_inc};
    assign br_sum  = {1'b0, pc_q} + {i_offset[MSB-1], i_offset};

`ifdef PC_RAS_EN
    logic           push, pop, ras_empty;
    logic [MSB-1:0] ras_top;

    pc_ras #(.MSB(MSB), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i (inc_sum[MSB-1:0]),
        .top_o  (ras_top),
        .empty_o(ras_empty),
        .err_o  (o_ras_err)
    );
`endif

    // run-control next state and PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = 1'b0;
`ifdef PC_RAS_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (i_halt) state_d = ST_HALT;
                else if (i_stall) state_d = ST_STALL;
                else if (enable) begin
`ifdef PC_RAS_EN
                    if (i_call) begin
                        pc_d = i_target;
                        push = 1'b1;
                    end else if (i_ret) begin
                        pop  = 1'b1;
                        pc_d = ras_empty ? pc_q : ras_top;
                    end else
`endif
                    if (i_jump) pc_d = i_target;
                    else if (i_branch) begin
                        pc_d   = br_sum[MSB-1:0];
                        wrap_d = br_sum[MSB];
                    end else begin
                        pc_d   = inc_sum[MSB-1:0];
                        wrap_d = inc_sum[MSB];
                    end
                end
            end
            ST_STALL: state_d = i_halt ? ST_HALT : (i_stall ? ST_STALL : ST_RUN);
            default: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    pc_d    = RST_PC;
                end
            end
        endcase
    end

    // state, PC and wrap pulse registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RST_PC;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_pc     = pc_q;
    assign o_wrap   = wrap_q;
    assign o_halted = state_q == ST_HALT;
    assign o_valid  = state_q == ST_RUN && !i_stall && !i_halt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table with an expected-result queue for pc_sequencer, plus reset and call/return sequences.
module tb_pc_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 0, en = 0, stall = 0, halt = 0, br = 0, jmp = 0;
    logic [10:0] inc = '0, off = '0, tgt = '0;
    logic [10:0] pc;
    logic        valid, halted, wrap;
`ifdef PC_RAS_EN
    logic        call = 0, ret = 0, ras_err;
`endif

    int n_vec = 0, n_err = 0;

    typedef struct {
        logic st, en, stl, hlt;
        logic [10:0] inc;
        logic br;
        logic [10:0] off;
        logic jmp;
        logic [10:0] tgt;
        logic v;
        logic [10:0] pc;
        logic h, w;
    } vec_t;

    typedef struct {
        logic [10:0] pc;
        logic h, w;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    pc_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .enable(en),
        .i_stall(stall), .i_halt(halt), .i_inc(inc), .i_branch(br),
        .i_offset(off), .i_jump(jmp), .i_target(tgt),
`ifdef PC_RAS_EN
        .i_call(call), .i_ret(ret), .o_ras_err(ras_err),
`endif
        .o_pc(pc), .o_valid(valid), .o_halted(halted), .o_wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic st, logic e, logic stl, logic hlt, int i, logic b, int o,
                                logic j, int t, logic v, int p, logic h, logic w);
        vec_t r;
        r.st = st; r.en = e; r.stl = stl; r.hlt = hlt; r.inc = 11'(i); r.br = b; r.off = 11'(o);
        r.jmp = j; r.tgt = 11'(t); r.v = v; r.pc = 11'(p); r.h = h; r.w = w;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        exp_t e;
        start = t.st; en = t.en; stall = t.stl; halt = t.hlt; inc = t.inc;
        br = t.br; off = t.off; jmp = t.jmp; tgt = t.tgt;
        #1 chk({nm, ".valid"}, 32'(valid), 32'(t.v));
        e.pc = t.pc; e.h = t.h; e.w = t.w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, ".pc"}, 32'(pc), 32'(e.pc));
        chk({nm, ".halted"}, 32'(halted), 32'(e.h));
        chk({nm, ".wrap"}, 32'(wrap), 32'(e.w));
    endtask

    initial begin
        //        st en stl hlt inc  br off   jmp tgt   v  pc   h  w
        vt.push_back(mk(1, 1, 0, 0, 10, 0, 0,    0, 0,    0, 0,    0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    1, 10,   0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    1, 20,   0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    1, 30,   0, 0));
        vt.push_back(mk(0, 0, 0, 0, 10, 0, 0,    0, 0,    1, 30,   0, 0));
        vt.push_back(mk(0, 0, 0, 0, 10, 0, 0,    0, 0,    1, 30,   0, 0));
        vt.push_back(mk(0, 0, 0, 0, 10, 0, 0,    0, 0,    1, 30,   0, 0));
        vt.push_back(mk(0, 1, 1, 0, 10, 0, 0,    0, 0,    0, 30,   0, 0));
        vt.push_back(mk(0, 1, 1, 0, 10, 0, 0,    0, 0,    0, 30,   0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    0, 30,   0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    1, 40,   0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 1, 2040, 0, 0,    1, 32,   0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 1, 2040, 1, 100,  1, 100,  0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    1, 2040, 1, 2040, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    1, 2,    0, 1));
        vt.push_back(mk(0, 0, 0, 0, 10, 0, 0,    0, 0,    1, 2,    0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2,  0, 0,    0, 0,    1, 4,    0, 0));
        vt.push_back(mk(0, 1, 0, 0, 2,  1, 2040, 0, 0,    1, 2044, 0, 1));
        vt.push_back(mk(0, 1, 0, 0, 0,  0, 0,    0, 0,    1, 2044, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 0,  0, 0,    1, 5,    1, 5,    0, 0));
        vt.push_back(mk(0, 1, 0, 1, 10, 0, 0,    0, 0,    0, 5,    1, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    1, 300,  0, 5,    1, 0));
        vt.push_back(mk(1, 1, 0, 0, 10, 0, 0,    0, 0,    0, 0,    0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    0, 0,    1, 10,   0, 0));
        vt.push_back(mk(1, 1, 0, 0, 10, 0, 0,    0, 0,    1, 20,   0, 0));
        vt.push_back(mk(0, 1, 1, 1, 10, 0, 0,    0, 0,    0, 20,   1, 0));
        vt.push_back(mk(1, 1, 0, 0, 10, 0, 0,    0, 0,    0, 0,    0, 0));
        vt.push_back(mk(0, 1, 1, 0, 10, 0, 0,    0, 0,    0, 0,    0, 0));
        vt.push_back(mk(1, 1, 1, 0, 10, 0, 0,    0, 0,    0, 0,    0, 0));
        vt.push_back(mk(0, 1, 0, 1, 10, 0, 0,    0, 0,    0, 0,    1, 0));
        vt.push_back(mk(1, 1, 0, 0, 10, 0, 0,    0, 0,    0, 0,    0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    1, 2000, 1, 2000, 0, 0));
        vt.push_back(mk(0, 1, 0, 0, 10, 1, 100,  0, 0,    1, 52,   0, 1));
        vt.push_back(mk(0, 1, 0, 0, 10, 0, 0,    1, 500,  1, 500,  0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc", 32'(pc), 0);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.wrap", 32'(wrap), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) apply(vt[i], $sformatf("v%0d", i));

        // asynchronous reset between edges while running from 500
        start = 0; en = 1; stall = 0; halt = 0; br = 0; jmp = 0; inc = 11'd10;
        @(posedge clk);
        #1 chk("arst.pre_pc", 32'(pc), 510);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.pc", 32'(pc), 0);
        chk("arst.valid", 32'(valid), 0);
        chk("arst.halted", 32'(halted), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("arst.idle_pc", 32'(pc), 0);
        chk("arst.idle_valid", 32'(valid), 0);

`ifdef PC_RAS_EN
        apply(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "ras.start");
        for (int k = 1; k <= 5; k++) begin
            call = 1;
            apply(mk(0, 1, 0, 0, 1, 0, 0, 0, 100 * k, 1, 100 * k, 0, 0), $sformatf("call%0d", k));
            chk($sformatf("call%0d.err", k), 32'(ras_err), 32'(k == 5));
        end
        call = 0;
        for (int k = 4; k >= 1; k--) begin
            ret = 1;
            apply(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 100 * k + 1, 0, 0), $sformatf("ret%0d", k));
            chk($sformatf("ret%0d.err", k), 32'(ras_err), 0);
        end
        apply(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 101, 0, 0), "ret_empty");
        chk("ret_empty.err", 32'(ras_err), 1);
        ret = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the BIP-style processor datapath.
- Adds to the plain increment-on-enable PC:
  - a run-control FSM (idle/run/stall/halt);
  - relative branch and absolute jump loading;
  - a configurable increment step;
  - a wrap indicator.
- Feeds the instruction-memory address and the pipeline's fetch-valid qualifier.

Parameters:
- MSB, 11, PC width in bits.
- RESET_PC, 0, PC value loaded on reset and on i_start.
- RAS_DEPTH, 4, return-address stack entries (used only with PC_RAS_EN; power of two, ≥2).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse: leave IDLE/HALT, PC:=RESET_PC.
- enable  in  1  advance permission; PC holds when low.
- i_stall  in  1  pipeline stall; PC holds, FSM goes to STALL.
- i_halt  in  1  halt request (HLT opcode).
- i_inc  in  MSB  increment step.
- i_branch  in  1  relative branch strobe.
- i_offset  in  MSB  signed two's-complement branch offset.
- i_jump  in  1  absolute jump strobe.
- i_target  in  MSB  jump target.
- o_pc  out  MSB  current PC.
- o_valid  out  1  o_pc is a fetch address this cycle (FSM in RUN).
- o_halted  out  1  FSM in HALT.
- o_wrap  out  1  one-cycle pulse: last update overflowed/underflowed modulo 2^MSB.

Behaviour:
- Reset (async, i_rst_n=0): o_pc=RESET_PC, FSM=IDLE, o_valid=0, o_halted=0, o_wrap=0, RAS emptied.
- FSM states: IDLE, RUN, STALL, HALT.
  - IDLE: i_start → RUN, PC:=RESET_PC. Everything else ignored.
  - RUN:
    - i_halt → HALT, PC holds.
    - else i_stall → STALL, PC holds.
    - else if enable, PC updates per priority below.
  - STALL: i_halt → HALT; !i_stall → RUN. PC holds while in STALL.
  - HALT: i_start → RUN, PC:=RESET_PC. Everything else ignored.
- PC update priority in RUN with enable=1, highest first:
  - i_jump: PC:=i_target.
  - i_branch: PC:=PC+sext(i_offset).
  - otherwise: PC:=PC+i_inc.
- Latency: one cycle. The new PC is visible on o_pc the cycle after the qualifying edge.
- Arithmetic is MSB-bit modulo.
  - o_wrap=1 for one cycle when an increment produces a carry out of bit MSB-1.
  - o_wrap=1 for one cycle when a branch result leaves the range [0, 2^MSB-1]: signed compare of the MSB+1-bit sum.
  - Jumps never set o_wrap.
- o_valid = (state==RUN) && !i_stall && !i_halt. This is combinational from state and inputs, registered state only.
- enable=0 in RUN: PC holds, o_valid still 1, o_wrap=0.
- i_jump and i_branch together: jump wins.
- i_start in RUN or STALL is ignored.
- i_halt and i_stall together: halt wins.
- i_inc=0 is legal: PC holds with no wrap.
- Reset asserted mid-operation returns immediately to the reset values, independent of the clock.

Optional Feature:
- Macro PC_RAS_EN adds ports i_call (1), i_ret (1), and o_ras_err (1).
- With the macro defined:
  - i_call behaves as i_jump and also pushes PC+i_inc.
  - i_ret pops: PC:=top of stack.
  - Priority: call > ret > jump > branch > inc.
  - Push when full overwrites the oldest entry (circular) and pulses o_ras_err.
  - Pop when empty holds the PC and pulses o_ras_err.
  - Stack pointer resets to empty.
- Without the macro: no extra ports or stack logic, and behaviour is exactly as above.

Decomposition:
- Shared package pc_pkg holds:
  - the FSM state encoding localparams (ST_IDLE=2'b00, ST_RUN=2'b01, ST_STALL=2'b10, ST_HALT=2'b11);
  - the default MSB;
  - the RESET_PC default.
- One sub-module, pc_ras (parametrised by MSB and RAS_DEPTH), instantiated only under PC_RAS_EN.

Test Plan:
1. Reset, then start: i_rst_n low 2 cycles, release, i_start pulse, enable=1, i_inc=11'd10 → o_pc sequence 0, 10, 20, 30; o_valid=1 from the cycle after start.
2. Enable gating and stall: enable low 3 cycles → o_pc holds at 30; i_stall high 2 cycles → o_valid=0 and PC holds; on release PC resumes at 40.
3. Branch/jump priority: PC=40, i_offset=-8 with i_branch → 32; i_jump=1 with i_target=100 and i_branch=1 in the same cycle → 100.
4. Wrap: PC=2040, i_inc=10 → o_pc=2, o_wrap=1 for exactly one cycle. Branch from 4 with offset -8 → 2044, o_wrap=1.
5. Halt and restart: i_halt in RUN → o_halted=1, o_valid=0, PC frozen. Then i_jump is ignored, and i_start gives o_pc=RESET_PC, back in RUN.
6. Async reset mid-run: drop i_rst_n between clock edges at PC=500 → o_pc=0 and FSM=IDLE before the next edge. With PC_RAS_EN: 5 calls with RAS_DEPTH=4 → o_ras_err pulses on the 5th call, and 4 returns recover the last 4 pushed addresses in order.
